// File: rtl/cdc_sync_filter_pkg.sv
// ----------------------------------------------------------------------------
// cdc_sync_filter_pkg
// Shared definitions for the synchroniser / glitch-filter bank.
//   - cnt_width(): width of the per-channel agreement counter, max(1, clog2(F))
//   - flt_action_e: what the filter does on a given clock edge
// ----------------------------------------------------------------------------
package cdc_sync_filter_pkg;

    // Width of a counter that must hold values 0 .. FILTER-1.
    function automatic int cnt_width(input int filter);
        return (filter <= 1) ? 1 : $clog2(filter);
    endfunction

    // Per-edge filter decision.
    typedef enum logic [1:0] {
        FLT_IDLE   = 2'd0,  // synced value agrees with output: counter clears
        FLT_COUNT  = 2'd1,  // disagreement still being qualified
        FLT_ACCEPT = 2'd2   // disagreement held long enough: output follows
    } flt_action_e;

endpackage

// File: rtl/cdc_sync_filter_ch.sv
// ----------------------------------------------------------------------------
// cdc_sync_filter_ch
// One channel: STAGES-deep synchroniser, consecutive-cycle glitch filter and
// registered rise/fall pulse generation.
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_data   asynchronous input bit
//   out_data  synchronised, filtered level (direct flop output)
//   rise      one-cycle pulse in the first cycle out_data shows a 0->1 change
//   fall      one-cycle pulse in the first cycle out_data shows a 1->0 change
// ----------------------------------------------------------------------------
module cdc_sync_filter_ch
    import cdc_sync_filter_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter int   FILTER    = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_data,
    output logic out_data,
    output logic rise,
    output logic fall
);

    localparam int             CW       = cnt_width(FILTER);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

    // Only sync_reg[0] may go metastable; keep the chain as discrete,
    // tightly placed flops rather than a shift-register primitive.
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [STAGES-1:0] sync_reg;

    logic              f_reg;
    logic              f_next;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     cnt_next;
    logic              rise_reg;
    logic              fall_reg;
    logic              s;
    flt_action_e       action;

    assign s = sync_reg[STAGES-1];

    always_comb begin
        action   = FLT_IDLE;
        f_next   = f_reg;
        cnt_next = '0;
        if (s != f_reg) begin
            action = (cnt_reg == CNT_LAST) ? FLT_ACCEPT : FLT_COUNT;
        end
        case (action)
            FLT_COUNT:  cnt_next = cnt_reg + CW'(1);
            FLT_ACCEPT: f_next   = s;
            default:    cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RESET_VAL}};
            f_reg    <= RESET_VAL;
            cnt_reg  <= '0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], in_data};
            f_reg    <= f_next;
            cnt_reg  <= cnt_next;
            // Pulses share the edge that updates f_reg, so they line up with
            // the first cycle the new level is visible.
            rise_reg <= (action == FLT_ACCEPT) &  s;
            fall_reg <= (action == FLT_ACCEPT) & ~s;
        end
    end

    assign out_data = f_reg;
    assign rise     = rise_reg;
    assign fall     = fall_reg;

endmodule

// File: rtl/cdc_sync_filter.sv
// ----------------------------------------------------------------------------
// cdc_sync_filter
// Bank of N independent input synchronisers with glitch filter and edge
// detection. Channels are not coherent with each other: never use this for
// multi-bit buses.
// Ports:
//   clk       sole clock, rising edge
//   rst_n     asynchronous active-low reset (release assumed synchronised)
//   in_data   N asynchronous inputs
//   out_data  N synchronised, filtered levels
//   rise      N one-cycle 0->1 pulses
//   fall      N one-cycle 1->0 pulses
// ----------------------------------------------------------------------------
module cdc_sync_filter
    import cdc_sync_filter_pkg::*;
#(
    parameter int         N         = 1,
    parameter int         STAGES    = 2,
    parameter int         FILTER    = 1,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    output logic [N-1:0] out_data,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            cdc_sync_filter_ch #(
                .STAGES    (STAGES),
                .FILTER    (FILTER),
                .RESET_VAL (RESET_VAL[gi])
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_data  (in_data[gi]),
                .out_data (out_data[gi]),
                .rise     (rise[gi]),
                .fall     (fall[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cdc_sync_filter.sv
// ----------------------------------------------------------------------------
// tb_cdc_sync_filter
// Three instances:
//   dut_a: N=4, STAGES=2, FILTER=4, RESET_VAL=4'b1010 (reset, latency, glitch)
//   dut_b: N=4, STAGES=3, FILTER=1                    (per-cycle toggling)
//   dut_c: N=8, STAGES=2, FILTER=8, RESET_VAL=8'hA5   (mid-count reset, random)
// Inputs are driven on the falling edge, outputs compared on the next falling
// edge through a queue of expected results.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cdc_sync_filter;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n, rst_c_n;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;
    logic [7:0] in_c, out_c, rise_c, fall_c;

    always #5 clk = ~clk;

    cdc_sync_filter #(.N(4), .STAGES(2), .FILTER(4), .RESET_VAL(4'b1010)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .in_data(in_a),
        .out_data(out_a), .rise(rise_a), .fall(fall_a));

    cdc_sync_filter #(.N(4), .STAGES(3), .FILTER(1), .RESET_VAL(4'b0000)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .in_data(in_b),
        .out_data(out_b), .rise(rise_b), .fall(fall_b));

    cdc_sync_filter #(.N(8), .STAGES(2), .FILTER(8), .RESET_VAL(8'hA5)) dut_c (
        .clk(clk), .rst_n(rst_c_n), .in_data(in_c),
        .out_data(out_c), .rise(rise_c), .fall(fall_c));

    typedef struct {
        logic [7:0] in;
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    typedef struct {
        logic [7:0] out;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state for dut_c (STAGES=2, FILTER=8)
    logic [7:0] m_s0, m_s1, m_f, m_rise, m_fall;
    int         m_cnt [8];

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp_v);
        end
    endtask

    task automatic drive(input int dut, input logic [7:0] v);
        case (dut)
            0:       in_a = v[3:0];
            1:       in_b = v[3:0];
            default: in_c = v;
        endcase
    endtask

    task automatic sample(input int dut, output logic [7:0] o, output logic [7:0] r, output logic [7:0] f);
        case (dut)
            0:       begin o = {4'b0, out_a}; r = {4'b0, rise_a}; f = {4'b0, fall_a}; end
            1:       begin o = {4'b0, out_b}; r = {4'b0, rise_b}; f = {4'b0, fall_b}; end
            default: begin o = out_c; r = rise_c; f = fall_c; end
        endcase
    endtask

    task automatic compare(input int dut, input exp_t e, input string nm, input int idx, input bit verbose);
        logic [7:0] o, r, f;
        sample(dut, o, r, f);
        chk({nm, "_out"},  idx, o, e.out);
        chk({nm, "_rise"}, idx, r, e.rise);
        chk({nm, "_fall"}, idx, f, e.fall);
        chk({nm, "_excl"}, idx, r & f, 8'h00);
        if (verbose)
            $display("%s[%0d] out=%h rise=%h fall=%h (exp %h/%h/%h)",
                     nm, idx, o, r, f, e.out, e.rise, e.fall);
    endtask

    // Drive one vector per falling edge; compare at the following falling edge.
    task automatic run_vecs(input int dut, input vec_t v[$], input string nm);
        exp_t e;
        for (int i = 0; i < v.size(); i++) begin
            drive(dut, v[i].in);
            sb.push_back('{v[i].out, v[i].rise, v[i].fall});
            @(negedge clk);
            e = sb.pop_front();
            compare(dut, e, nm, i, 1'b1);
        end
    endtask

    task automatic model_reset();
        m_s0 = 8'hA5; m_s1 = 8'hA5; m_f = 8'hA5; m_rise = '0; m_fall = '0;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    endtask

    // Advance the reference by one rising edge with input x sampled.
    task automatic model_step(input logic [7:0] x);
        for (int i = 0; i < 8; i++) begin
            logic acc;
            acc = 1'b0;
            if (m_s1[i] == m_f[i]) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] == 7) begin
                acc = 1'b1;
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            m_rise[i] = acc &  m_s1[i];
            m_fall[i] = acc & ~m_s1[i];
            if (acc) m_f[i] = m_s1[i];
        end
        m_s1 = m_s0;
        m_s0 = x;
    endtask

    initial begin
        vec_t        v[$];
        logic [7:0]  o, r, f;
        logic [15:0] pat;
        logic        po, pprev;
        int          hold [8];
        exp_t        e;

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        in_a = '0; in_b = '0; in_c = 8'hA5;
        repeat (2) @(negedge clk);

        // Reset held while inputs toggle: outputs pinned to RESET_VAL.
        for (int i = 0; i < 6; i++) begin
            in_a = 4'($urandom);
            @(negedge clk);
            sample(0, o, r, f);
            chk("a_rst_out", i, o, 8'h0A);
            chk("a_rst_pulse", i, r | f, 8'h00);
        end
        in_a = 4'b1010;
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;

        // No pulse after release when inputs equal RESET_VAL.
        v.delete();
        for (int k = 1; k <= 8; k++) v.push_back('{8'h0A, 8'h0A, 8'h00, 8'h00});
        run_vecs(0, v, "a_idle");

        // Latency: ch0 steps high, visible with rise after edge 6.
        v.delete();
        for (int k = 1; k <= 8; k++)
            v.push_back('{8'h0B, (k >= 6) ? 8'h0B : 8'h0A, (k == 6) ? 8'h01 : 8'h00, 8'h00});
        run_vecs(0, v, "a_lat");

        // Glitch: ch2 high for 3 sampled cycles is rejected.
        v.delete();
        for (int k = 1; k <= 8; k++)
            v.push_back('{(k <= 3) ? 8'h0F : 8'h0B, 8'h0B, 8'h00, 8'h00});
        run_vecs(0, v, "a_glitch3");

        // 4 cycles high is accepted: rise after edge 6, fall after edge 10.
        v.delete();
        for (int k = 1; k <= 12; k++)
            v.push_back('{(k <= 4) ? 8'h0F : 8'h0B,
                          (k >= 6 && k <= 9) ? 8'h0F : 8'h0B,
                          (k == 6) ? 8'h04 : 8'h00,
                          (k == 10) ? 8'h04 : 8'h00});
        run_vecs(0, v, "a_glitch4");

        // FILTER=1, STAGES=3: ch2 toggles each cycle for 10 cycles; output
        // reproduces the pattern three edges later with alternating pulses.
        pat = '0;
        for (int k = 1; k <= 10; k++) pat[k] = k[0];
        v.delete();
        pprev = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            po = (k >= 4) ? pat[k-3] : 1'b0;
            v.push_back('{{5'b0, pat[k], 2'b0}, {5'b0, po, 2'b0},
                          {5'b0, po & ~pprev, 2'b0}, {5'b0, ~po & pprev, 2'b0}});
            pprev = po;
        end
        run_vecs(1, v, "b_toggle");

        // dut_c: bring ch1 high so out_c differs from RESET_VAL.
        v.delete();
        for (int k = 1; k <= 10; k++)
            v.push_back('{8'hA7, (k == 10) ? 8'hA7 : 8'hA5, (k == 10) ? 8'h02 : 8'h00, 8'h00});
        run_vecs(2, v, "c_pre");

        // ch0 low, counting: after 7 edges its counter sits at 5.
        v.delete();
        for (int k = 1; k <= 7; k++) v.push_back('{8'hA6, 8'hA7, 8'h00, 8'h00});
        run_vecs(2, v, "c_count");

        // Asynchronous reset mid-count: outputs return before any edge.
        rst_c_n = 1'b0;
        #1;
        sample(2, o, r, f);
        chk("c_arst_out", 0, o, 8'hA5);
        chk("c_arst_pulse", 0, r | f, 8'h00);
        @(negedge clk);
        sample(2, o, r, f);
        chk("c_arst_out", 1, o, 8'hA5);
        chk("c_arst_pulse", 1, r | f, 8'h00);
        rst_c_n = 1'b1;

        // Fresh full count after release: change only after edge 10.
        v.delete();
        for (int k = 1; k <= 12; k++)
            v.push_back('{8'hA6, (k >= 10) ? 8'hA6 : 8'hA5,
                          (k == 10) ? 8'h02 : 8'h00, (k == 10) ? 8'h01 : 8'h00});
        run_vecs(2, v, "c_fresh");

        // Random independent channels against the reference model.
        rst_c_n = 1'b0;
        in_c = 8'hA5;
        model_reset();
        @(negedge clk);
        rst_c_n = 1'b1;
        for (int i = 0; i < 8; i++) hold[i] = $urandom_range(1, 14);
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++) begin
                hold[i] = hold[i] - 1;
                if (hold[i] == 0) begin
                    in_c[i] = ~in_c[i];
                    hold[i] = $urandom_range(1, 14);
                end
            end
            model_step(in_c);
            sb.push_back('{m_f, m_rise, m_fall});
            @(negedge clk);
            e = sb.pop_front();
            compare(2, e, "c_rand", c, (m_rise | m_fall) != 8'h00 && c < 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
